wb_queue: RTL

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 106 ++++++++++
 1 files changed

// File: rtl/wb_queue.sv
// Write-back queue: merges ALU and mult/div results into one regfile write port.
// Pending entries are bypassed to the register read ports, youngest match first.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_reg,
  input  logic [31:0]              alu_data,
  output logic                     alu_ready,
  input  logic                     md_valid,
  input  logic [4:0]               md_reg,
  input  logic [31:0]              md_data,
  output logic                     md_ready,
  output logic                     ctrl_writeEnable,
  output logic [4:0]               ctrl_writeReg,
  output logic [31:0]              data_writeReg,
  input  logic [4:0]               ctrl_readRegA,
  input  logic [4:0]               ctrl_readRegB,
  output logic                     fwdA_hit,
  output logic [31:0]              fwdA_data,
  output logic                     fwdB_hit,
  output logic [31:0]              fwdB_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTHC = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]  rg;
    logic [31:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   cnt;

  logic            aluPush;
  logic            mdPush;
  logic            pop;
  logic [CW-1:0]   nPush;
  logic [AW-1:0]   mdSlot;

  assign count = cnt;
  assign full  = (cnt == DEPTHC);
  assign pop   = (cnt != '0);

  // Ready never counts this cycle's pop; the ALU claims a free slot first.
  assign alu_ready = ctrl_reset && (cnt < DEPTHC);
  assign md_ready  = ctrl_reset &&
                     ((cnt + CW'(alu_valid)) < DEPTHC);

  assign aluPush = alu_valid && alu_ready && (alu_reg != '0);
  assign mdPush  = md_valid && md_ready && (md_reg != '0);
  assign nPush   = CW'(aluPush) + CW'(mdPush);
  assign mdSlot  = tail + AW'(aluPush);

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + AW'(pop);
      tail <= tail + AW'(nPush);
      cnt  <= cnt + nPush - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (aluPush) mem[tail] <= '{rg: alu_reg, data: alu_data};
    if (mdPush)  mem[mdSlot] <= '{rg: md_reg, data: md_data};
  end

  assign ctrl_writeEnable = pop;
  assign ctrl_writeReg    = pop ? mem[head].rg : '0;
  assign data_writeReg    = pop ? mem[head].data : '0;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwdA_hit  = 1'b0;
    fwdA_data = '0;
    fwdB_hit  = 1'b0;
    fwdB_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < cnt) begin
        if (ctrl_readRegA != '0 &&
            mem[head + AW'(k)].rg == ctrl_readRegA) begin
          fwdA_hit  = 1'b1;
          fwdA_data = mem[head + AW'(k)].data;
        end
        if (ctrl_readRegB != '0 &&
            mem[head + AW'(k)].rg == ctrl_readRegB) begin
          fwdB_hit  = 1'b1;
          fwdB_data = mem[head + AW'(k)].data;
        end
      end
    end
  end

endmodule
